vga_frame_capture: RTL
======================

VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iHS  input  1  horizontal sync, active low.
REQ-006 iVS  input  1  vertical sync, active low.
REQ-007 iBLANK_n  input  1  high during active video.
REQ-008 r_data, g_data, b_data  input  8 each  pixel colour.
REQ-009 capture_req  input  1  one-cycle request to capture the next full frame.
REQ-010 abort  input  1  cancel an armed or running capture.
REQ-011 wr_en  output  1  framebuffer write strobe.
REQ-012 wr_addr  output  19  framebuffer word address.
REQ-013 wr_data  output  8  packed pixel {r_data[7:5], g_data[7:5], b_data[7:6]}.
REQ-014 busy  output  1  high in ARM or CAPTURE.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 frame_err  output  1  timing-error flag for the last completed frame, valid from done until the next done or reset.

Function
REQ-017 All sync, blank and pixel inputs SHALL be registered once; edge detection and write generation use the registered copies.
REQ-018 Write latency SHALL be 2 cycles: a pixel present at the inputs at edge N appears as wr_en/wr_data at edge N+2.
REQ-019 Frame start SHALL be a falling edge of registered iVS (previous 1, current 0).
REQ-020 States SHALL be IDLE, ARM, CAPTURE, DONE.
REQ-021 IDLE: capture_req=1 with abort=0 -> ARM; otherwise stay.
REQ-022 ARM: frame start -> CAPTURE, clearing pixel address, line count, pixel count and error accumulator.
REQ-023 CAPTURE: each registered cycle with iBLANK_n=1 and address < H_ACTIVE*V_ACTIVE SHALL issue one write at the current address, then increment the address by 1.
REQ-024 CAPTURE: active pixels with address >= H_ACTIVE*V_ACTIVE SHALL NOT be written and SHALL set the overflow error.
REQ-025 Per-line pixel count SHALL clear on iBLANK_n rising edge; on iBLANK_n falling edge, a count != H_ACTIVE SHALL set the line error and the line count SHALL increment.
REQ-026 CAPTURE: next frame start -> DONE; frame_err := line error OR overflow OR line count != V_ACTIVE OR address != H_ACTIVE*V_ACTIVE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-028 abort=1 in ARM or CAPTURE SHALL return to IDLE on the next edge, with no further writes and no done pulse; frame_err unchanged.
REQ-029 capture_req SHALL be ignored outside IDLE; abort SHALL win over simultaneous capture_req.
REQ-030 wr_en SHALL be 0 in IDLE, ARM and DONE; wr_addr and wr_data hold their last values when wr_en=0.
REQ-031 A frame start in the same cycle as an active pixel SHALL end the frame before that pixel is counted.

Reset
REQ-032 reset=1 at any edge SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0, and clear all counters and input registers (iHS/iVS registers to 1, iBLANK_n register to 0).
REQ-033 Reset mid-capture SHALL suppress the write pipeline the same cycle; no done pulse follows.

Verification
REQ-034 Nominal 640x480 timing from video_sync_generator, capture_req pulse -> writes to addresses 0..307199 in order, one done pulse, frame_err=0.
REQ-035 Pixel at addr 0 with r=0xFF, g=0x00, b=0xC0 -> wr_data=0xE3 two cycles after the input.
REQ-036 Line 10 shortened to 639 active pixels -> done with frame_err=1.
REQ-037 Frame with 481 active lines -> final 640 pixels not written, frame_err=1.
REQ-038 abort asserted mid-frame (addr ~1000) -> wr_en low from next edge, busy=0, no done; new capture_req then captures cleanly.
REQ-039 reset asserted mid-capture -> all outputs at reset values next cycle; capture_req ignored while reset=1.

Source files
------------

// File: rtl/vga_frame_capture.sv
// VGA frame capture: snoops a VGA pixel stream and, on request, writes one
// complete frame into a framebuffer as packed 8-bit RGB332 words.
//
// Ports:
//   vga_clk, reset          pixel clock, synchronous active-high reset
//   iHS, iVS                sync inputs, active low
//   iBLANK_n                high during active video
//   r_data/g_data/b_data    8-bit colour channels
//   capture_req, abort      arm a capture of the next frame / cancel it
//   wr_en, wr_addr, wr_data framebuffer write port (2-cycle latency)
//   busy, done, frame_err   status: armed/capturing, completion pulse,
//                           timing-error flag of the last completed frame
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  r_data,
    input  logic [7:0]  g_data,
    input  logic [7:0]  b_data,
    input  logic        capture_req,
    input  logic        abort,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam logic [18:0] TOTAL = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [15:0] H_CNT = 16'(H_ACTIVE);
    localparam logic [15:0] V_CNT = 16'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_e;

    state_e      state_q;
    logic        unused_hs_q;
    logic        vs_q;
    logic        vs_prev_q;
    logic        blank_q;
    logic        blank_prev_q;
    logic [7:0]  pix_q;
    logic [18:0] addr_q;
    logic [15:0] line_cnt_q;
    logic [15:0] pix_cnt_q;
    logic        line_err_q;
    logic        ovf_q;
    logic        wr_en_q;
    logic [18:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        busy_q;
    logic        done_q;
    logic        frame_err_q;

    logic frame_start;
    logic unused_bits;

    // Edges are taken between the two registered copies of each input.
    assign frame_start = vs_prev_q & ~vs_q;

    // hsync is registered with the rest but nothing depends on it; the low
    // colour bits are dropped by the RGB332 packing.
    assign unused_bits = ^{r_data[4:0], g_data[4:0], b_data[5:0], unused_hs_q};

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            unused_hs_q  <= 1'b1;
            vs_q         <= 1'b1;
            vs_prev_q    <= 1'b1;
            blank_q      <= 1'b0;
            blank_prev_q <= 1'b0;
            pix_q        <= '0;
            addr_q       <= '0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            unused_hs_q  <= iHS;
            vs_q         <= iVS;
            vs_prev_q    <= vs_q;
            blank_q      <= iBLANK_n;
            blank_prev_q <= blank_q;
            pix_q        <= {r_data[7:5], g_data[7:5], b_data[7:6]};
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (capture_req && !abort) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_start) begin
                        state_q    <= CAPTURE;
                        addr_q     <= '0;
                        line_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        line_err_q <= 1'b0;
                        ovf_q      <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_start) begin
                        // Frame ends before any pixel of this cycle counts.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        frame_err_q <= line_err_q | ovf_q |
                                       (line_cnt_q != V_CNT) |
                                       (addr_q != TOTAL);
                    end else if (blank_q) begin
                        if (addr_q < TOTAL) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= pix_q;
                            addr_q    <= addr_q + 19'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        // Rising edge restarts the count at this pixel.
                        pix_cnt_q <= blank_prev_q ? pix_cnt_q + 16'd1
                                                  : 16'd1;
                    end else if (blank_prev_q) begin
                        if (pix_cnt_q != H_CNT) line_err_q <= 1'b1;
                        line_cnt_q <= line_cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

endmodule
